// File: rtl/calc_entry_fsm_if.sv
// Handshake bundle between the key-entry sequencer and the arithmetic unit.
// The sequencer is the master: it presents operands/opcode and raises
// calc_req; the arithmetic unit answers with a one-cycle calc_ack carrying
// the result and an error flag.
interface calc_entry_fsm_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] operand_a;
    logic [4*DIGITS-1:0] operand_b;
    logic [1:0]          opcode;
    logic                calc_req;
    logic                calc_ack;
    logic [4*DIGITS-1:0] result_in;
    logic                result_err;

    modport master (
        output operand_a,
        output operand_b,
        output opcode,
        output calc_req,
        input  calc_ack,
        input  result_in,
        input  result_err
    );

    modport slave (
        input  operand_a,
        input  operand_b,
        input  opcode,
        input  calc_req,
        output calc_ack,
        output result_in,
        output result_err
    );
endinterface

// File: rtl/calc_entry_fsm.sv
// Key-entry sequencer for the calculator.
// Turns keypad presses (tecla/ready) into BCD operands A/B and an opcode,
// issues one compute request per '=' over the calc_req/calc_ack handshake,
// and selects what the 7-segment path displays.
// Optional feature: define CALC_CHAIN_EN so that an operator pressed while a
// result is shown copies the result into A and starts a chained operation.
// Without it, only a digit or clear leaves the RESULT state.
module calc_entry_fsm #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            tecla,
    input  logic                  ready,
    calc_entry_fsm_if.master      calc,
    output logic [4*DIGITS-1:0]   display,
    output logic                  error
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        WAIT_ACK,
        RESULT,
        ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     a, a_nxt;
    logic [W-1:0]     b, b_nxt;
    logic [W-1:0]     res, res_nxt;
    logic [CNT_W-1:0] a_cnt, a_cnt_nxt;
    logic [CNT_W-1:0] b_cnt, b_cnt_nxt;
    logic [1:0]       op, op_nxt;

    logic r1, r2;
    logic key_event;
    logic is_digit, is_op, is_eq, is_clr;

    // Shift a new BCD digit into the least significant nibble.
    function automatic logic [W-1:0] shift_digit(input logic [W-1:0] old,
                                                 input logic [3:0]   dig);
        return W'({old, dig});
    endfunction

    // Map operator keys 0xA..0xD onto add/sub/mul/div opcodes.
    function automatic logic [1:0] key_opcode(input logic [3:0] k);
        case (k)
            4'hA:    return 2'b00;
            4'hB:    return 2'b01;
            4'hC:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Two-stage ready history; an event is the first cycle r1 sees ready high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= ready;
            r2 <= r1;
        end
    end

    assign key_event = r1 & ~r2;
    assign is_digit  = key_event && (tecla <= 4'd9);
    assign is_op     = key_event && (tecla >= 4'hA) && (tecla <= 4'hD);
    assign is_eq     = key_event && (tecla == 4'hE);
    assign is_clr    = key_event && (tecla == 4'hF);

    // State and operand registers; everything visible on the outputs resets to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ENTER_A;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            a_cnt <= '0;
            b_cnt <= '0;
            op    <= 2'b00;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            res   <= res_nxt;
            a_cnt <= a_cnt_nxt;
            b_cnt <= b_cnt_nxt;
            op    <= op_nxt;
        end
    end

    // Next-state and register updates; clear overrides every state, including an ack in flight.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        res_nxt   = res;
        a_cnt_nxt = a_cnt;
        b_cnt_nxt = b_cnt;
        op_nxt    = op;

        if (is_clr) begin
            state_nxt = ENTER_A;
            a_nxt     = '0;
            b_nxt     = '0;
            res_nxt   = '0;
            a_cnt_nxt = '0;
            b_cnt_nxt = '0;
            op_nxt    = 2'b00;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit) begin
                        if (a_cnt < CNT_MAX) begin
                            a_nxt     = shift_digit(a, tecla);
                            a_cnt_nxt = a_cnt + CNT_W'(1);
                        end
                    end else if (is_op) begin
                        op_nxt    = key_opcode(tecla);
                        b_nxt     = '0;
                        b_cnt_nxt = '0;
                        state_nxt = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        if (b_cnt < CNT_MAX) begin
                            b_nxt     = shift_digit(b, tecla);
                            b_cnt_nxt = b_cnt + CNT_W'(1);
                        end
                    end else if (is_op) begin
                        // The operator may be changed only until B gets its first digit.
                        if (b_cnt == '0) begin
                            op_nxt = key_opcode(tecla);
                        end
                    end else if (is_eq) begin
                        if (b_cnt != '0) begin
                            state_nxt = WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    // Keys other than clear are dropped while the request is outstanding.
                    if (calc.calc_ack) begin
                        res_nxt   = calc.result_in;
                        state_nxt = calc.result_err ? ERROR : RESULT;
                    end
                end
                RESULT: begin
                    if (is_digit) begin
                        a_nxt     = W'(tecla);
                        a_cnt_nxt = CNT_W'(1);
                        state_nxt = ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_op) begin
                        a_nxt     = res;
                        a_cnt_nxt = CNT_MAX;
                        op_nxt    = key_opcode(tecla);
                        b_nxt     = '0;
                        b_cnt_nxt = '0;
                        state_nxt = ENTER_B;
                    end
`endif
                end
                ERROR: begin
                    state_nxt = ERROR;
                end
                default: begin
                    state_nxt = ENTER_A;
                end
            endcase
        end
    end

    // Display source selection; B replaces A only once it has a digit.
    always_comb begin
        display = a;
        case (state)
            ENTER_A:  display = a;
            ENTER_B:  display = (b_cnt == '0) ? a : b;
            WAIT_ACK: display = b;
            RESULT:   display = res;
            ERROR:    display = '1;
            default:  display = a;
        endcase
    end

    assign calc.operand_a = a;
    assign calc.operand_b = b;
    assign calc.opcode    = op;
    assign calc.calc_req  = (state == WAIT_ACK);
    assign error          = (state == ERROR);

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm: a table of key/ack vectors with
// expected outputs, hand-written timing sequences, and a randomized run
// checked against a digit-list reference model.
module tb_calc_entry_fsm;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    localparam int MA = 0;  // entering A
    localparam int MB = 1;  // entering B
    localparam int MW = 2;  // request outstanding
    localparam int MR = 3;  // showing result
    localparam int ME = 4;  // error

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   tecla;
    logic         ready;
    logic [W-1:0] display;
    logic         error;

    int total = 0;
    int bad   = 0;

    calc_entry_fsm_if #(.DIGITS(DIGITS)) bus ();

    calc_entry_fsm #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tecla   (tecla),
        .ready   (ready),
        .calc    (bus),
        .display (display),
        .error   (error)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit           is_ack;
        logic [3:0]   key;
        logic [W-1:0] res;
        bit           rerr;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        bit           req;
        logic [W-1:0] disp;
        bit           err;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    int           m_mode;
    int           a_q[$];
    int           b_q[$];
    logic [1:0]   m_op;
    logic [W-1:0] m_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] op, input bit req, input logic [W-1:0] d, input bit e);
        chk({tag, ".operand_a"}, 32'(bus.operand_a), 32'(a));
        chk({tag, ".operand_b"}, 32'(bus.operand_b), 32'(b));
        chk({tag, ".opcode"},    32'(bus.opcode),    32'(op));
        chk({tag, ".calc_req"},  32'(bus.calc_req),  32'(req));
        chk({tag, ".display"},   32'(display),       32'(d));
        chk({tag, ".error"},     32'(error),         32'(e));
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        tecla = k;
        ready = 1'b1;
        repeat (hold) tick();
        ready = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic ack(input logic [W-1:0] r, input bit e);
        bus.result_in  = r;
        bus.result_err = e;
        bus.calc_ack   = 1'b1;
        tick();
        bus.calc_ack   = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        m_mode = MA;
        a_q.delete();
        b_q.delete();
        m_op  = 2'b00;
        m_res = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        tecla = 4'h0;
        bus.calc_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    function automatic logic [W-1:0] pack_a();
        int v = 0;
        foreach (a_q[i]) v = v * 16 + a_q[i];
        return W'(v);
    endfunction

    function automatic logic [W-1:0] pack_b();
        int v = 0;
        foreach (b_q[i]) v = v * 16 + b_q[i];
        return W'(v);
    endfunction

    task automatic model_key(input int k);
        if (k == 15) begin
            model_reset();
        end else begin
            case (m_mode)
                MA: begin
                    if (k <= 9) begin
                        if (a_q.size() < DIGITS) a_q.push_back(k);
                    end else if (k <= 13) begin
                        m_op = 2'(k - 10);
                        b_q.delete();
                        m_mode = MB;
                    end
                end
                MB: begin
                    if (k <= 9) begin
                        if (b_q.size() < DIGITS) b_q.push_back(k);
                    end else if (k <= 13) begin
                        if (b_q.size() == 0) m_op = 2'(k - 10);
                    end else if (b_q.size() > 0) begin
                        m_mode = MW;
                    end
                end
                MR: begin
                    if (k <= 9) begin
                        a_q.delete();
                        a_q.push_back(k);
                        m_mode = MA;
                    end else if (k <= 13) begin
`ifdef CALC_CHAIN_EN
                        a_q.delete();
                        for (int i = DIGITS - 1; i >= 0; i--) a_q.push_back(int'((m_res >> (4 * i)) & 'hF));
                        m_op = 2'(k - 10);
                        b_q.delete();
                        m_mode = MB;
`endif
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_ack(input logic [W-1:0] r, input bit e);
        if (m_mode == MW) begin
            m_res  = r;
            m_mode = e ? ME : MR;
        end
    endtask

    function automatic logic [W-1:0] model_disp();
        case (m_mode)
            MA:      return pack_a();
            MB:      return (b_q.size() == 0) ? pack_a() : pack_b();
            MW:      return pack_b();
            MR:      return m_res;
            default: return '1;
        endcase
    endfunction

    task automatic check_model(input string tag);
        check_all(tag, pack_a(), pack_b(), m_op, (m_mode == MW), model_disp(), (m_mode == ME));
    endtask

    function automatic vec_t vk(input logic [3:0] k, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] op, input bit req, input logic [W-1:0] d, input bit e);
        vec_t v;
        v.is_ack = 1'b0; v.key = k; v.res = '0; v.rerr = 1'b0;
        v.a = a; v.b = b; v.op = op; v.req = req; v.disp = d; v.err = e;
        return v;
    endfunction

    function automatic vec_t va(input logic [W-1:0] r, input bit re, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [1:0] op, input bit req,
                                input logic [W-1:0] d, input bit e);
        vec_t v;
        v.is_ack = 1'b1; v.key = 4'h0; v.res = r; v.rerr = re;
        v.a = a; v.b = b; v.op = op; v.req = req; v.disp = d; v.err = e;
        return v;
    endfunction

    initial begin
        bus.calc_ack   = 1'b0;
        bus.result_in  = '0;
        bus.result_err = 1'b0;

        // ---------------- vector table ----------------
        tbl.push_back(vk(4'h1, 16'h0001, 16'h0000, 2'd0, 0, 16'h0001, 0));
        tbl.push_back(vk(4'h2, 16'h0012, 16'h0000, 2'd0, 0, 16'h0012, 0));
        tbl.push_back(vk(4'hA, 16'h0012, 16'h0000, 2'd0, 0, 16'h0012, 0));
        tbl.push_back(vk(4'h3, 16'h0012, 16'h0003, 2'd0, 0, 16'h0003, 0));
        tbl.push_back(vk(4'hE, 16'h0012, 16'h0003, 2'd0, 1, 16'h0003, 0));
        tbl.push_back(va(16'h0015, 0, 16'h0012, 16'h0003, 2'd0, 0, 16'h0015, 0));
        tbl.push_back(vk(4'hE, 16'h0012, 16'h0003, 2'd0, 0, 16'h0015, 0));
        tbl.push_back(vk(4'hF, 16'h0000, 16'h0000, 2'd0, 0, 16'h0000, 0));
        tbl.push_back(vk(4'h9, 16'h0009, 16'h0000, 2'd0, 0, 16'h0009, 0));
        tbl.push_back(vk(4'hD, 16'h0009, 16'h0000, 2'd3, 0, 16'h0009, 0));
        tbl.push_back(vk(4'hC, 16'h0009, 16'h0000, 2'd2, 0, 16'h0009, 0));
        tbl.push_back(vk(4'hB, 16'h0009, 16'h0000, 2'd1, 0, 16'h0009, 0));
        tbl.push_back(vk(4'hE, 16'h0009, 16'h0000, 2'd1, 0, 16'h0009, 0));
        tbl.push_back(vk(4'h0, 16'h0009, 16'h0000, 2'd1, 0, 16'h0000, 0));
        tbl.push_back(vk(4'hE, 16'h0009, 16'h0000, 2'd1, 1, 16'h0000, 0));
        tbl.push_back(va(16'h1234, 1, 16'h0009, 16'h0000, 2'd1, 0, 16'hFFFF, 1));
        tbl.push_back(vk(4'h7, 16'h0009, 16'h0000, 2'd1, 0, 16'hFFFF, 1));
        tbl.push_back(vk(4'hE, 16'h0009, 16'h0000, 2'd1, 0, 16'hFFFF, 1));
        tbl.push_back(va(16'h5555, 0, 16'h0009, 16'h0000, 2'd1, 0, 16'hFFFF, 1));
        tbl.push_back(vk(4'hF, 16'h0000, 16'h0000, 2'd0, 0, 16'h0000, 0));
        tbl.push_back(vk(4'h1, 16'h0001, 16'h0000, 2'd0, 0, 16'h0001, 0));
        tbl.push_back(vk(4'h2, 16'h0012, 16'h0000, 2'd0, 0, 16'h0012, 0));
        tbl.push_back(vk(4'h3, 16'h0123, 16'h0000, 2'd0, 0, 16'h0123, 0));
        tbl.push_back(vk(4'h4, 16'h1234, 16'h0000, 2'd0, 0, 16'h1234, 0));
        tbl.push_back(vk(4'h5, 16'h1234, 16'h0000, 2'd0, 0, 16'h1234, 0));
        tbl.push_back(vk(4'hE, 16'h1234, 16'h0000, 2'd0, 0, 16'h1234, 0));
        tbl.push_back(vk(4'hC, 16'h1234, 16'h0000, 2'd2, 0, 16'h1234, 0));
        tbl.push_back(vk(4'h5, 16'h1234, 16'h0005, 2'd2, 0, 16'h0005, 0));
        tbl.push_back(vk(4'hA, 16'h1234, 16'h0005, 2'd2, 0, 16'h0005, 0));
        tbl.push_back(vk(4'hE, 16'h1234, 16'h0005, 2'd2, 1, 16'h0005, 0));
        tbl.push_back(vk(4'h3, 16'h1234, 16'h0005, 2'd2, 1, 16'h0005, 0));
        tbl.push_back(va(16'h0007, 0, 16'h1234, 16'h0005, 2'd2, 0, 16'h0007, 0));
        tbl.push_back(vk(4'h8, 16'h0008, 16'h0005, 2'd2, 0, 16'h0008, 0));

        do_reset();
        check_all("reset", '0, '0, 2'd0, 0, '0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].is_ack) ack(tbl[i].res, tbl[i].rerr);
            else press(tbl[i].key, 2, 2);
            check_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
                      tbl[i].req, tbl[i].disp, tbl[i].err);
        end

        // ---------------- long hold: single event ----------------
        do_reset();
        tecla = 4'h5;
        ready = 1'b1;
        repeat (10000) tick();
        ready = 1'b0;
        repeat (2) tick();
        chk("hold.operand_a", 32'(bus.operand_a), 32'h0005);
        chk("hold.display", 32'(display), 32'h0005);

        // ---------------- request timing ----------------
        do_reset();
        press(4'h1, 2, 2);
        press(4'hA, 2, 2);
        press(4'h2, 2, 2);
        tecla = 4'hE;
        ready = 1'b1;
        chk("req.before", 32'(bus.calc_req), 32'h0);
        tick();
        chk("req.event_cycle", 32'(bus.calc_req), 32'h0);
        tick();
        chk("req.rise", 32'(bus.calc_req), 32'h1);
        ready = 1'b0;
        repeat (20) tick();
        chk("req.held", 32'(bus.calc_req), 32'h1);
        chk("req.frozen_a", 32'(bus.operand_a), 32'h0001);
        bus.result_in  = 16'h0003;
        bus.result_err = 1'b0;
        bus.calc_ack   = 1'b1;
        chk("req.high_on_ack", 32'(bus.calc_req), 32'h1);
        tick();
        bus.calc_ack = 1'b0;
        chk("req.drop", 32'(bus.calc_req), 32'h0);
        chk("req.display", 32'(display), 32'h0003);
        press(4'hE, 2, 2);
        chk("req.no_rerise", 32'(bus.calc_req), 32'h0);

        // ---------------- clear during WAIT_ACK ----------------
        do_reset();
        press(4'h1, 2, 2);
        press(4'hA, 2, 2);
        press(4'h2, 2, 2);
        press(4'hE, 2, 2);
        chk("clrwait.req_up", 32'(bus.calc_req), 32'h1);
        tecla = 4'hF;
        ready = 1'b1;
        tick();
        chk("clrwait.event_cycle", 32'(bus.calc_req), 32'h1);
        tick();
        check_all("clrwait.after", '0, '0, 2'd0, 0, '0, 0);
        ready = 1'b0;
        repeat (3) tick();
        ack(16'h0099, 1'b0);
        check_all("clrwait.late_ack", '0, '0, 2'd0, 0, '0, 0);
        press(4'h3, 2, 2);
        chk("clrwait.enter_a", 32'(display), 32'h0003);

        // ---------------- ack and key in the same cycle ----------------
        do_reset();
        press(4'h4, 2, 2);
        press(4'hA, 2, 2);
        press(4'h1, 2, 2);
        press(4'hE, 2, 2);
        tecla = 4'h7;
        ready = 1'b1;
        tick();
        bus.result_in  = 16'h0005;
        bus.result_err = 1'b0;
        bus.calc_ack   = 1'b1;
        tick();
        bus.calc_ack = 1'b0;
        ready = 1'b0;
        repeat (2) tick();
        check_all("ackkey", 16'h0004, 16'h0001, 2'd0, 0, 16'h0005, 0);
        press(4'h2, 2, 2);
        press(4'hA, 2, 2);
        press(4'h3, 2, 2);
        press(4'hE, 2, 2);
        tecla = 4'hF;
        ready = 1'b1;
        tick();
        bus.result_in  = 16'h0077;
        bus.result_err = 1'b1;
        bus.calc_ack   = 1'b1;
        tick();
        bus.calc_ack = 1'b0;
        ready = 1'b0;
        repeat (2) tick();
        check_all("ackclr", '0, '0, 2'd0, 0, '0, 0);

        // ---------------- operator while a result is shown ----------------
        do_reset();
        press(4'h1, 2, 2);
        press(4'h2, 2, 2);
        press(4'hA, 2, 2);
        press(4'h3, 2, 2);
        press(4'hE, 2, 2);
        ack(16'h0015, 1'b0);
        press(4'hC, 2, 2);
`ifdef CALC_CHAIN_EN
        check_all("chain.op", 16'h0015, 16'h0000, 2'd2, 0, 16'h0015, 0);
        press(4'h2, 2, 2);
        press(4'hE, 2, 2);
        check_all("chain.req", 16'h0015, 16'h0002, 2'd2, 1, 16'h0002, 0);
`else
        check_all("nochain.op", 16'h0012, 16'h0003, 2'd0, 0, 16'h0015, 0);
        press(4'h2, 2, 2);
        check_all("nochain.digit", 16'h0002, 16'h0003, 2'd0, 0, 16'h0002, 0);
`endif

        // ---------------- reset in the middle of entry ----------------
        do_reset();
        press(4'h4, 2, 2);
        press(4'h2, 2, 2);
        press(4'hA, 2, 2);
        chk("rstmid.before", 32'(display), 32'h0042);
        rst_n = 1'b0;
        tick();
        check_all("rstmid.after", '0, '0, 2'd0, 0, '0, 0);
        rst_n = 1'b1;
        tick();
        press(4'h5, 2, 2);
        check_all("rstmid.enter_a", 16'h0005, '0, 2'd0, 0, 16'h0005, 0);
        rst_n = 1'b0;
        tecla = 4'h6;
        ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        repeat (2) tick();
        chk("rstheld.operand_a", 32'(bus.operand_a), 32'h0006);

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int s = 0; s < 400; s++) begin
            int r;
            bit do_ack;
            do_ack = (m_mode == MW) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            if (do_ack) begin
                logic [W-1:0] rv;
                bit ev;
                rv = W'($urandom());
                ev = ($urandom_range(0, 4) == 0);
                ack(rv, ev);
                model_ack(rv, ev);
            end else begin
                int k;
                r = int'($urandom_range(0, 99));
                if (r < 55)      k = int'($urandom_range(0, 9));
                else if (r < 75) k = int'($urandom_range(10, 13));
                else if (r < 90) k = 14;
                else             k = 15;
                press(4'(k), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
                model_key(k);
            end
            check_model($sformatf("rand%0d", s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
